// File: rtl/inst_load_ctrl_if.sv
// Bus bundle for inst_load_ctrl: fetch path, loader stream and memory write port.
// The ld_sum signal exists only when INST_LOAD_CHECKSUM_EN is defined.
interface inst_load_ctrl_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       fetch_addr;
  logic              fetch_stall;
  logic              ld_start;
  logic [31:0]       ld_base;
  logic [31:0]       ld_len;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              ld_busy;
  logic              ld_done;
  logic              ld_err;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write;
`ifdef INST_LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] ld_sum;
`endif

  // master: the controller itself; slave: fetch unit, loader and memory around it
  modport master (
    input  fetch_addr, ld_start, ld_base, ld_len, ld_valid, ld_data,
    output fetch_stall, ld_ready, ld_busy, ld_done, ld_err,
    output mem_addr, mem_write_data, mem_write
`ifdef INST_LOAD_CHECKSUM_EN
    , output ld_sum
`endif
  );

  modport slave (
    output fetch_addr, ld_start, ld_base, ld_len, ld_valid, ld_data,
    input  fetch_stall, ld_ready, ld_busy, ld_done, ld_err,
    input  mem_addr, mem_write_data, mem_write
`ifdef INST_LOAD_CHECKSUM_EN
    , input ld_sum
`endif
  );
endinterface

// File: rtl/inst_load_ctrl.sv
// Program-load controller: arbitrates the instruction memory port between fetch and a
// streaming loader. Define INST_LOAD_CHECKSUM_EN to add the ld_sum running checksum.
module inst_load_ctrl #(
  parameter int MEM_DEPTH = 1001,
  parameter int DATA_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  inst_load_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, GRANT, LOAD, DONE} state_t;

  state_t            state_reg;
  logic [31:0]       base_reg;
  logic [31:0]       len_reg;
  logic [31:0]       cnt_reg;
  logic              stall_reg;
  logic              ready_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              err_reg;

  logic [32:0]       range_end;
  logic              len_zero;
  logic              range_bad;
  logic              accept;
  logic              last_word;
  logic [DATA_W-1:0] wr_data;

  // 33-bit end address so a huge base + len cannot wrap back into range
  assign range_end = {1'b0, bus.ld_base} + {1'b0, bus.ld_len};
  assign len_zero  = (bus.ld_len == 32'd0);
  assign range_bad = !len_zero && (range_end > 33'(MEM_DEPTH));
  assign accept    = ready_reg && bus.ld_valid;
  assign last_word = accept && (cnt_reg == len_reg - 32'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      base_reg  <= 32'd0;
      len_reg   <= 32'd0;
      cnt_reg   <= 32'd0;
      stall_reg <= 1'b0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.ld_start) begin
            base_reg <= bus.ld_base;
            len_reg  <= bus.ld_len;
            cnt_reg  <= 32'd0;
            err_reg  <= range_bad;
            busy_reg <= 1'b1;
            // Rejected or empty loads never take the port away from fetch
            if (len_zero || range_bad) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= GRANT;
              stall_reg <= 1'b1;
            end
          end
        end
        GRANT: begin
          state_reg <= LOAD;
          ready_reg <= 1'b1;
        end
        LOAD: begin
          if (accept) begin
            cnt_reg <= cnt_reg + 32'd1;
            if (last_word) begin
              state_reg <= DONE;
              ready_reg <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          stall_reg <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // The write port belongs to the loader only while words are being accepted
  assign wr_data            = ready_reg ? bus.ld_data : '0;
  assign bus.mem_addr       = ready_reg ? (base_reg + cnt_reg) : bus.fetch_addr;
  assign bus.mem_write_data = wr_data;
  assign bus.mem_write      = ready_reg && bus.ld_valid;

  assign bus.fetch_stall = stall_reg;
  assign bus.ld_ready    = ready_reg;
  assign bus.ld_busy     = busy_reg;
  assign bus.ld_done     = done_reg;
  assign bus.ld_err      = err_reg;

`ifdef INST_LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] sum_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_reg <= '0;
    end else if (state_reg == IDLE && bus.ld_start) begin
      sum_reg <= '0;
    end else if (accept) begin
      sum_reg <= sum_reg + bus.ld_data;
    end
  end

  assign bus.ld_sum = sum_reg;
`endif

endmodule
